// File: rtl/fifo_generator_pkg.sv
// Shared types and constants for the fifo_generator FWFT AXI4-Stream byte FIFO.
package fifo_generator_pkg;

    localparam int unsigned DATA_W_DEF       = 8;
    localparam int unsigned RST_BUSY_CYC_DEF = 4;

    // Pointer width: address bits plus one wrap bit.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic                  last;
        logic [DATA_W_DEF-1:0] data;
    } axis_beat_t;

endpackage

// File: rtl/fifo_generator_ram.sv
// Simple dual-port storage: synchronous write, combinational read.
module fifo_generator_ram #(
    parameter  int unsigned WIDTH = 9,
    parameter  int unsigned DEPTH = 1024,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             dri_clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data_c
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge dri_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/fifo_generator.sv
// Single-clock first-word-fall-through AXI4-Stream FIFO of {tlast, tdata} beats.
// Define FIFO_PACKET_MODE_EN to hold output until a complete frame is stored.
module fifo_generator
    import fifo_generator_pkg::*;
#(
    parameter  int unsigned DATA_W       = DATA_W_DEF,
    parameter  int unsigned DEPTH        = 1024,
    parameter  int unsigned RST_BUSY_CYC = RST_BUSY_CYC_DEF,
    localparam int unsigned PTR_W        = ptr_w(DEPTH)
) (
    input  logic              s_aclk,
    input  logic              s_aresetn,
    output logic              wr_rst_busy,
    output logic              rd_rst_busy,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic [PTR_W-1:0]  data_count
`ifdef FIFO_PACKET_MODE_EN
    ,
    output logic [PTR_W-1:0]  frames_stored
`endif
);

    localparam int unsigned AW = PTR_W - 1;
    localparam int unsigned BW = (RST_BUSY_CYC < 1) ? 1 : $clog2(RST_BUSY_CYC + 1);

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W-1:0] wr_ptr_nxt, rd_ptr_nxt, count_nxt;
    logic [BW-1:0]    busy_cnt, busy_cnt_nxt;
    logic             busy_nxt, full_nxt, empty_nxt;
    logic             push, pop, tvalid_nxt, tready_nxt;
    beat_t            in_beat, head_nxt;
    logic [DATA_W:0]  ram_rd;
`ifdef FIFO_PACKET_MODE_EN
    logic [PTR_W-1:0] frames_nxt;
`endif

    fifo_generator_ram #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_ram (
        .dri_clk   (s_aclk),
        .wr_en     (push),
        .wr_addr   (wr_ptr[AW-1:0]),
        .wr_data   (in_beat),
        .rd_addr   (rd_ptr_nxt[AW-1:0]),
        .rd_data_c (ram_rd)
    );

    // Next-state: handshakes, pointers, head prefetch and registered flag values.
    always_comb begin
        push         = s_axis_tvalid && s_axis_tready;
        pop          = m_axis_tvalid && m_axis_tready;
        in_beat      = '{last: s_axis_tlast, data: s_axis_tdata};
        wr_ptr_nxt   = wr_ptr + PTR_W'(push);
        rd_ptr_nxt   = rd_ptr + PTR_W'(pop);
        count_nxt    = wr_ptr_nxt - rd_ptr_nxt;
        empty_nxt    = (wr_ptr_nxt == rd_ptr_nxt);
        full_nxt     = (wr_ptr_nxt[PTR_W-1] != rd_ptr_nxt[PTR_W-1]) &&
                       (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
        busy_cnt_nxt = (busy_cnt != '0) ? busy_cnt - BW'(1) : busy_cnt;
        busy_nxt     = (busy_cnt_nxt != '0);

        // A new head either already sits in RAM or is the beat being written right now.
        head_nxt = '{last: m_axis_tlast, data: m_axis_tdata};
        if (rd_ptr_nxt != wr_ptr) begin
            head_nxt = beat_t'(ram_rd);
        end else if (push) begin
            head_nxt = in_beat;
        end

        tready_nxt = !busy_nxt && !full_nxt;
        tvalid_nxt = !busy_nxt && !empty_nxt;
`ifdef FIFO_PACKET_MODE_EN
        frames_nxt = frames_stored + PTR_W'(push && s_axis_tlast) - PTR_W'(pop && m_axis_tlast);
        // Full escape releases frames longer than the FIFO instead of deadlocking.
        tvalid_nxt = tvalid_nxt && ((frames_nxt != '0) || full_nxt);
`endif
    end

    always_ff @(posedge s_aclk) begin
        if (!s_aresetn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            data_count    <= '0;
            busy_cnt      <= BW'(RST_BUSY_CYC);
            wr_rst_busy   <= 1'b1;
            rd_rst_busy   <= 1'b1;
            s_axis_tready <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
`ifdef FIFO_PACKET_MODE_EN
            frames_stored <= '0;
`endif
        end else begin
            wr_ptr        <= wr_ptr_nxt;
            rd_ptr        <= rd_ptr_nxt;
            data_count    <= count_nxt;
            busy_cnt      <= busy_cnt_nxt;
            wr_rst_busy   <= busy_nxt;
            rd_rst_busy   <= busy_nxt;
            s_axis_tready <= tready_nxt;
            m_axis_tvalid <= tvalid_nxt;
            m_axis_tdata  <= head_nxt.data;
            m_axis_tlast  <= head_nxt.last;
`ifdef FIFO_PACKET_MODE_EN
            frames_stored <= frames_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_generator.sv
// Randomized self-checking bench for fifo_generator against a queue-based reference model.
module tb_fifo_generator;
    import fifo_generator_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned PW    = $clog2(DEPTH) + 1;

    logic          s_aclk = 1'b0;
    logic          s_aresetn = 1'b0;
    logic          wr_rst_busy, rd_rst_busy;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [7:0]    s_axis_tdata = 8'h00;
    logic          s_axis_tlast = 1'b0;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic [7:0]    m_axis_tdata;
    logic          m_axis_tlast;
    logic [PW-1:0] data_count;
`ifdef FIFO_PACKET_MODE_EN
    logic [PW-1:0] frames_stored;
`endif

    fifo_generator #(
        .DATA_W       (8),
        .DEPTH        (DEPTH),
        .RST_BUSY_CYC (RST_BUSY_CYC_DEF)
    ) dut (
        .s_aclk        (s_aclk),
        .s_aresetn     (s_aresetn),
        .wr_rst_busy   (wr_rst_busy),
        .rd_rst_busy   (rd_rst_busy),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .data_count    (data_count)
`ifdef FIFO_PACKET_MODE_EN
        ,
        .frames_stored (frames_stored)
`endif
    );

    always #5 s_aclk = ~s_aclk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         busy_left = RST_BUSY_CYC_DEF;
    axis_beat_t model_q[$];
    axis_beat_t out_log[$];
    axis_beat_t sent[$];
    logic       stall_prev = 1'b0;
    axis_beat_t data_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_frames();
        int n = 0;
        foreach (model_q[i]) if (model_q[i].last) n++;
        return n;
    endfunction

    // One clock: compare outputs with the model, drive inputs, advance the model past the edge.
    task automatic cyc(input logic rstn, input logic v, input logic [7:0] d, input logic l,
                       input logic r);
        logic exp_busy, exp_rdy, exp_vld, push, pop;
        int   sz;
        sz       = model_q.size();
        exp_busy = (busy_left > 0);
        exp_rdy  = !exp_busy && (sz < int'(DEPTH));
        exp_vld  = !exp_busy && (sz > 0);
`ifdef FIFO_PACKET_MODE_EN
        exp_vld  = exp_vld && ((model_frames() > 0) || (sz == int'(DEPTH)));
        check("frames_stored", 32'(frames_stored), 32'(model_frames()));
`endif
        check("wr_rst_busy", 32'(wr_rst_busy), 32'(exp_busy));
        check("rd_rst_busy", 32'(rd_rst_busy), 32'(exp_busy));
        check("s_axis_tready", 32'(s_axis_tready), 32'(exp_rdy));
        check("m_axis_tvalid", 32'(m_axis_tvalid), 32'(exp_vld));
        check("data_count", 32'(data_count), 32'(sz));
        if (exp_vld) begin
            check("m_axis_tdata", 32'(m_axis_tdata), 32'(model_q[0].data));
            check("m_axis_tlast", 32'(m_axis_tlast), 32'(model_q[0].last));
        end
        if (stall_prev && m_axis_tvalid)
            check("hold_stable", 32'({m_axis_tlast, m_axis_tdata}), 32'(data_prev));

        s_aresetn     = rstn;
        s_axis_tvalid = v;
        s_axis_tdata  = v ? d : 8'($urandom);
        s_axis_tlast  = l;
        m_axis_tready = r;
        if (rstn && m_axis_tvalid && r) out_log.push_back('{last: m_axis_tlast, data: m_axis_tdata});
        stall_prev = rstn && m_axis_tvalid && !r;
        data_prev  = '{last: m_axis_tlast, data: m_axis_tdata};
        push = v && exp_rdy;
        pop  = exp_vld && r;

        @(posedge s_aclk);
        if (!rstn) begin
            model_q.delete();
            busy_left = RST_BUSY_CYC_DEF;
        end else begin
            if (pop) void'(model_q.pop_front());
            if (push) model_q.push_back('{last: l, data: d});
            if (busy_left > 0) busy_left--;
        end
        @(negedge s_aclk);
    endtask

    // Offer one beat until the DUT accepts it; r_pct is the downstream ready probability.
    task automatic push_beat(input logic [7:0] d, input logic l, input int r_pct);
        bit   done = 1'b0;
        logic r;
        for (int t = 0; t < 300 && !done; t++) begin
            r    = (int'($urandom_range(99)) < r_pct);
            done = s_axis_tready;
            cyc(1'b1, 1'b1, d, l, r);
        end
        if (!done) check("push_timeout", 32'(0), 32'(1));
        sent.push_back('{last: l, data: d});
    endtask

    task automatic drain(input int n_expect, input int r_pct);
        logic r;
        for (int t = 0; t < 600 && out_log.size() < n_expect; t++) begin
            r = (int'($urandom_range(99)) < r_pct) || (t > 400);
            cyc(1'b1, 1'b0, 8'h00, 1'b0, r);
        end
        if (out_log.size() < n_expect) check("drain_timeout", 32'(out_log.size()), 32'(n_expect));
        for (int t = 0; t < 4; t++) cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_len"}, 32'(out_log.size()), 32'(sent.size()));
        for (int i = 0; i < sent.size() && i < out_log.size(); i++)
            check({tag, "_beat"}, 32'(out_log[i]), 32'(sent[i]));
        out_log.delete();
        sent.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1);
    end

    initial begin
        int acc;
        @(posedge s_aclk);
        @(negedge s_aclk);

        // Reset: 5 cycles low, then busy for RST_BUSY_CYC edges.
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("rst_tdata", 32'(m_axis_tdata), 32'(0));
        check("rst_tlast", 32'(m_axis_tlast), 32'(0));
        for (int k = 1; k <= 6; k++) begin
            cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
            check("busy_release", 32'(wr_rst_busy), 32'(k < 4));
        end
        check("ready_after_rst", 32'(s_axis_tready), 32'(1));
        check("count_after_rst", 32'(data_count), 32'(0));

        // Frame pass-through with length header, downstream always ready.
        push_beat(8'h41, 1'b0, 100);
`ifdef FIFO_PACKET_MODE_EN
        check("first_latency", 32'(m_axis_tvalid), 32'(0));
`else
        check("first_latency", 32'(m_axis_tvalid), 32'(1));
`endif
        push_beat(8'h00, 1'b0, 100);
        for (int i = 0; i < 65; i++) push_beat(8'($urandom), 1'(i == 64), 100);
        drain(67, 100);
        compare_log("passthru");

        // Fill and overflow with downstream stalled.
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            if (s_axis_tready) begin
                acc++;
                sent.push_back('{last: 1'(i == 15), data: 8'(i)});
            end
            cyc(1'b1, 1'b1, 8'(i), 1'(i == 15), 1'b0);
        end
        check("fill_accepted", 32'(acc), 32'(16));
        check("fill_count", 32'(data_count), 32'(16));
        check("fill_ready", 32'(s_axis_tready), 32'(0));
        drain(16, 100);
        compare_log("fill_drain");
        check("drained_count", 32'(data_count), 32'(0));
        check("drained_valid", 32'(m_axis_tvalid), 32'(0));

        // Backpressure on a streamed frame.
        for (int i = 0; i < 40; i++) push_beat(8'($urandom), 1'(i == 39), 50);
        drain(40, 50);
        compare_log("backpressure");

        // Full with simultaneous pop and push.
        for (int i = 0; i < 16; i++) push_beat(8'(8'h80 + i), 1'b1, 0);
        check("full_count", 32'(data_count), 32'(16));
        cyc(1'b1, 1'b1, 8'hA0, 1'b1, 1'b1);
        check("full_pop_count", 32'(data_count), 32'(15));
        cyc(1'b1, 1'b1, 8'hA1, 1'b1, 1'b1);
        check("both_count", 32'(data_count), 32'(15));
        cyc(1'b1, 1'b1, 8'hA2, 1'b1, 1'b0);
        check("refill_count", 32'(data_count), 32'(16));
        out_log.delete();
        drain(16, 100);
        check("full_drain_len", 32'(out_log.size()), 32'(16));
        out_log.delete();

        // Reset mid-frame discards the partial frame.
        for (int i = 0; i < 10; i++) push_beat(8'($urandom), 1'b0, 0);
        sent.delete();
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("midrst_count", 32'(data_count), 32'(0));
        check("midrst_valid", 32'(m_axis_tvalid), 32'(0));
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) push_beat(8'($urandom), 1'(i == 19), 100);
        drain(20, 100);
        compare_log("after_midrst");

`ifdef FIFO_PACKET_MODE_EN
        // Frame held until its tlast beat is stored.
        for (int i = 0; i < 10; i++) begin
            push_beat(8'(8'h30 + i), 1'b0, 100);
            check("pkt_hold", 32'(m_axis_tvalid), 32'(0));
        end
        push_beat(8'h3A, 1'b1, 100);
        check("pkt_release", 32'(m_axis_tvalid), 32'(1));
        drain(11, 100);
        compare_log("pkt_frame");

        // Oversized frame escapes through the full condition.
        for (int i = 0; i < 16; i++) push_beat(8'(8'h50 + i), 1'b0, 0);
        check("pkt_escape", 32'(m_axis_tvalid), 32'(1));
        for (int i = 16; i < 20; i++) push_beat(8'(8'h50 + i), 1'(i == 19), 100);
        drain(20, 100);
        compare_log("pkt_big");
`endif

        // Random traffic with occasional resets.
        for (int i = 0; i < 800; i++)
            cyc(1'($urandom_range(149) != 0), 1'($urandom), 8'($urandom),
                1'($urandom_range(7) == 0), 1'($urandom));
        out_log.delete();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
